// File: rtl/range_threshold_sequencer_pkg.sv
// Shared types and constants for the range-detector threshold sequencer.
package range_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EVAL = 2'd2
  } state_e;

  // thr_ctrl byte layout: {nibble index, nibble value}
  localparam int NIB_IDX_W = 4;
  localparam int NIB_VAL_W = 4;

  localparam logic [63:0] DEF_INIT_THRESHOLD = 64'h1000_0000_0000_0000;
  localparam logic [63:0] DEF_MIN_THRESHOLD  = 64'h0000_0000_0000_0100;

endpackage

// File: rtl/range_threshold_sequencer_if.sv
// Config / peak-finder / threshold bundle of the threshold sequencer.
interface range_thr_if #(
  parameter int DATA_LEN = 64,
  parameter int CNT_W    = 32
) ();
  logic                cfg_wr;
  logic                cfg_clr;
  logic [7:0]          thr_ctrl_i;
  logic [7:0]          thr_ctrl_q;
  logic                auto_en;
  logic [15:0]         target_peaks;
  logic                iq_first;
  logic                pk_done_i;
  logic [31:0]         num_peaks_i;
  logic                pk_done_q;
  logic [31:0]         num_peaks_q;
  logic [DATA_LEN-1:0] threshold_i;
  logic [DATA_LEN-1:0] threshold_q;
  logic                thr_update;
  logic                busy;
  logic [CNT_W-1:0]    frame_count;
  logic [CNT_W-1:0]    miss_count;

  modport master (
    output cfg_wr, cfg_clr, thr_ctrl_i, thr_ctrl_q, auto_en, target_peaks,
    output iq_first, pk_done_i, num_peaks_i, pk_done_q, num_peaks_q,
    input  threshold_i, threshold_q, thr_update, busy, frame_count, miss_count
  );

  modport slave (
    input  cfg_wr, cfg_clr, thr_ctrl_i, thr_ctrl_q, auto_en, target_peaks,
    input  iq_first, pk_done_i, num_peaks_i, pk_done_q, num_peaks_q,
    output threshold_i, threshold_q, thr_update, busy, frame_count, miss_count
  );
endinterface

// File: rtl/range_threshold_sequencer_thr_step_adjust.sv
// One channel's auto-step: double on too many peaks (holding once the MSB
// is set), halve on zero peaks (floored at MIN_THRESHOLD), else hold.
// o_step_now is the combinational result, o_step the registered copy.
module thr_step_adjust
  import range_det_pkg::*;
#(
  parameter int                  DATA_LEN      = 64,
  parameter logic [DATA_LEN-1:0] MIN_THRESHOLD = DATA_LEN'(DEF_MIN_THRESHOLD)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [DATA_LEN-1:0] i_thr,
  input  logic [31:0]         i_num_peaks,
  input  logic [15:0]         i_target,
  output logic [DATA_LEN-1:0] o_step_now,
  output logic [DATA_LEN-1:0] o_step
);

  logic [DATA_LEN-1:0] w_half;

  // Saturating shift / floored halve
  always_comb begin
    w_half     = i_thr >> 1;
    o_step_now = i_thr;
    if (i_num_peaks > {16'd0, i_target}) begin
      if (!i_thr[DATA_LEN-1]) o_step_now = i_thr << 1;
    end else if (i_num_peaks == 32'd0) begin
      o_step_now = (w_half < MIN_THRESHOLD) ? MIN_THRESHOLD : w_half;
    end
  end

  // Hold the step result until the next commit
  always_ff @(posedge i_clk) begin
    if (i_rst)     o_step <= '0;
    else if (i_en) o_step <= o_step_now;
  end

endmodule

// File: rtl/range_threshold_sequencer.sv
// Frame-synchronous threshold controller for the I/Q peak-finder pair.
// Shadow thresholds are written nibble-wise and only reach the live
// thresholds on iq_first. Optional auto-step: define AUTO_THRESH_EN.
module range_threshold_sequencer
  import range_det_pkg::*;
#(
  parameter int                  DATA_LEN       = 64,
  parameter logic [DATA_LEN-1:0] INIT_THRESHOLD = DATA_LEN'(DEF_INIT_THRESHOLD),
  parameter logic [DATA_LEN-1:0] MIN_THRESHOLD  = DATA_LEN'(DEF_MIN_THRESHOLD),
  parameter int                  CNT_W          = 32
) (
  input  logic       i_aclk,
  input  logic       i_areset,
  range_thr_if.slave bus
);

  state_e              r_state, w_state_nxt;
  logic [DATA_LEN-1:0] r_shadow_i, r_shadow_q, r_thr_i, r_thr_q;
  logic [DATA_LEN-1:0] w_commit_i, w_commit_q;
  logic                r_dirty, r_thr_update, r_got_i, r_got_q;
  logic [CNT_W-1:0]    r_frame_cnt, r_miss_cnt;
  logic                w_eval, w_miss, w_clr_got;
  logic [5:0]          w_pos_i, w_pos_q;

  assign w_pos_i = {bus.thr_ctrl_i[NIB_VAL_W +: NIB_IDX_W], 2'b00};
  assign w_pos_q = {bus.thr_ctrl_q[NIB_VAL_W +: NIB_IDX_W], 2'b00};

  // State register
  always_ff @(posedge i_aclk) begin
    if (i_areset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state; iq_first in RUN aborts the frame as a miss
  always_comb begin
    w_state_nxt = r_state;
    w_eval      = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.iq_first) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (bus.iq_first) w_miss = 1'b1;
        else if ((r_got_i | bus.pk_done_i) && (r_got_q | bus.pk_done_q))
          w_state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        w_eval      = 1'b1;
        w_state_nxt = bus.iq_first ? ST_RUN : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_clr_got = bus.iq_first | w_eval;

  // Shadow writes; clear beats nibble write
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_shadow_i <= INIT_THRESHOLD;
      r_shadow_q <= INIT_THRESHOLD;
    end else if (bus.cfg_clr) begin
      r_shadow_i <= '0;
      r_shadow_q <= '0;
    end else if (bus.cfg_wr) begin
      r_shadow_i[w_pos_i +: NIB_VAL_W] <= bus.thr_ctrl_i[NIB_VAL_W-1:0];
      r_shadow_q[w_pos_q +: NIB_VAL_W] <= bus.thr_ctrl_q[NIB_VAL_W-1:0];
    end
  end

  // Dirty: a write arriving with a commit survives for the next frame
  always_ff @(posedge i_aclk) begin
    if (i_areset)                       r_dirty <= 1'b0;
    else if (bus.cfg_wr || bus.cfg_clr) r_dirty <= 1'b1;
    else if (bus.iq_first)              r_dirty <= 1'b0;
  end

`ifdef AUTO_THRESH_EN
  logic                w_step_en;
  logic                r_pending;
  logic [31:0]         r_peaks_i, r_peaks_q;
  logic [DATA_LEN-1:0] w_now_i, w_now_q, w_step_i, w_step_q;

  assign w_step_en = w_eval && bus.auto_en && !r_dirty;

  // Peak counts of the current frame, used by EVAL
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_peaks_i <= '0;
      r_peaks_q <= '0;
    end else if (r_state == ST_RUN && !bus.iq_first) begin
      if (bus.pk_done_i) r_peaks_i <= bus.num_peaks_i;
      if (bus.pk_done_q) r_peaks_q <= bus.num_peaks_q;
    end
  end

  // A step is pending from EVAL until the next commit consumes it
  always_ff @(posedge i_aclk) begin
    if (i_areset || bus.iq_first) r_pending <= 1'b0;
    else if (w_step_en)           r_pending <= 1'b1;
  end

  thr_step_adjust #(.DATA_LEN(DATA_LEN), .MIN_THRESHOLD(MIN_THRESHOLD)) u_step_i (
    .i_clk(i_aclk), .i_rst(i_areset), .i_en(w_step_en), .i_thr(r_thr_i),
    .i_num_peaks(r_peaks_i), .i_target(bus.target_peaks),
    .o_step_now(w_now_i), .o_step(w_step_i)
  );

  thr_step_adjust #(.DATA_LEN(DATA_LEN), .MIN_THRESHOLD(MIN_THRESHOLD)) u_step_q (
    .i_clk(i_aclk), .i_rst(i_areset), .i_en(w_step_en), .i_thr(r_thr_q),
    .i_num_peaks(r_peaks_q), .i_target(bus.target_peaks),
    .o_step_now(w_now_q), .o_step(w_step_q)
  );

  // Commit source: manual config, then a step (bypassed when EVAL meets iq_first)
  always_comb begin
    w_commit_i = r_thr_i;
    w_commit_q = r_thr_q;
    if (r_dirty) begin
      w_commit_i = r_shadow_i;
      w_commit_q = r_shadow_q;
    end else if (w_step_en) begin
      w_commit_i = w_now_i;
      w_commit_q = w_now_q;
    end else if (r_pending) begin
      w_commit_i = w_step_i;
      w_commit_q = w_step_q;
    end
  end
`else
  logic w_unused_auto;
  assign w_unused_auto = ^{bus.auto_en, bus.target_peaks, bus.num_peaks_i,
                           bus.num_peaks_q, MIN_THRESHOLD};

  // Commit source: shadow when dirty, otherwise hold
  always_comb begin
    w_commit_i = r_dirty ? r_shadow_i : r_thr_i;
    w_commit_q = r_dirty ? r_shadow_q : r_thr_q;
  end
`endif

  // Live thresholds change only at a frame boundary
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_thr_i      <= INIT_THRESHOLD;
      r_thr_q      <= INIT_THRESHOLD;
      r_thr_update <= 1'b0;
    end else begin
      r_thr_update <= bus.iq_first;
      if (bus.iq_first) begin
        r_thr_i <= w_commit_i;
        r_thr_q <= w_commit_q;
      end
    end
  end

  // Per-frame result flags; pulses coinciding with iq_first are dropped
  always_ff @(posedge i_aclk) begin
    if (i_areset || w_clr_got) begin
      r_got_i <= 1'b0;
      r_got_q <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_got_i <= r_got_i | bus.pk_done_i;
      r_got_q <= r_got_q | bus.pk_done_q;
    end
  end

  // Good / missed frame counters, wrapping
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_frame_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      if (w_eval) r_frame_cnt <= r_frame_cnt + 1'b1;
      if (w_miss) r_miss_cnt  <= r_miss_cnt + 1'b1;
    end
  end

  assign bus.threshold_i = r_thr_i;
  assign bus.threshold_q = r_thr_q;
  assign bus.thr_update  = r_thr_update;
  assign bus.busy        = (r_state == ST_RUN);
  assign bus.frame_count = r_frame_cnt;
  assign bus.miss_count  = r_miss_cnt;

endmodule

// File: tb/tb_range_threshold_sequencer.sv
// Bench for range_threshold_sequencer: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_range_threshold_sequencer;
  import range_det_pkg::*;

  localparam logic [63:0] INIT = 64'h1000_0000_0000_0000;
  localparam logic [63:0] MINT = 64'h0000_0000_0000_0100;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  range_thr_if #(.DATA_LEN(64), .CNT_W(32)) bus ();

  range_threshold_sequencer dut (
    .i_aclk  (aclk),
    .i_areset(areset),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [63:0] m_thr_i, m_thr_q, m_sh_i, m_sh_q, m_st_i, m_st_q;
  bit          m_dirty, m_pend, m_open;
  int unsigned m_frame, m_miss;

  function automatic logic [63:0] nib_write(input logic [63:0] v, input logic [7:0] c);
    int sh;
    sh = int'(c[7:4]) * 4;
    return (v & ~(64'hF << sh)) | (64'(c[3:0]) << sh);
  endfunction

  function automatic logic [63:0] model_step(input logic [63:0] thr, input int unsigned pk,
                                             input int unsigned tgt);
    if (pk > tgt) return (thr >= 64'h8000_0000_0000_0000) ? thr : thr * 2;
    if (pk == 0)  return (thr / 2 < MINT) ? MINT : thr / 2;
    return thr;
  endfunction

  function automatic logic [31:0] pick_peaks(input int unsigned tgt);
    case ($urandom_range(0, 2))
      0:       return 32'd0;
      1:       return 32'($urandom_range(1, tgt));
      default: return 32'(tgt + 1 + $urandom_range(0, 100));
    endcase
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cfg_wr = 0; bus.cfg_clr = 0; bus.thr_ctrl_i = 0; bus.thr_ctrl_q = 0;
    bus.iq_first = 0; bus.pk_done_i = 0; bus.pk_done_q = 0;
    bus.num_peaks_i = 0; bus.num_peaks_q = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    bus.auto_en = 0; bus.target_peaks = 0;
    areset = 1;
    tick(); tick();
    areset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.threshold_i !== INIT) begin n_bad++; $display("FAIL rst_thr_i got %h want %h", bus.threshold_i, INIT); end
    n_cmp++; if (bus.threshold_q !== INIT) begin n_bad++; $display("FAIL rst_thr_q got %h want %h", bus.threshold_q, INIT); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.thr_update !== 1'b0) begin n_bad++; $display("FAIL rst_upd got %b want 0", bus.thr_update); end
    n_cmp++; if (bus.frame_count !== 32'd0) begin n_bad++; $display("FAIL rst_frame got %0d want 0", bus.frame_count); end
    n_cmp++; if (bus.miss_count !== 32'd0) begin n_bad++; $display("FAIL rst_miss got %0d want 0", bus.miss_count); end
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    n_cmp++; if (bus.thr_update !== 1'b1) begin n_bad++; $display("FAIL first_upd got %b want 1", bus.thr_update); end
    n_cmp++; if (bus.threshold_i !== INIT) begin n_bad++; $display("FAIL first_thr_i got %h want %h", bus.threshold_i, INIT); end
    n_cmp++; if (bus.threshold_q !== INIT) begin n_bad++; $display("FAIL first_thr_q got %h want %h", bus.threshold_q, INIT); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL first_busy got %b want 1", bus.busy); end
    tick();
    n_cmp++; if (bus.thr_update !== 1'b0) begin n_bad++; $display("FAIL upd_pulse got %b want 0", bus.thr_update); end
  endtask

  task automatic test_shadow_commit();
    do_reset();
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    bus.cfg_clr = 1; tick(); bus.cfg_clr = 0;
    bus.cfg_wr = 1; bus.thr_ctrl_i = 8'hF3; bus.thr_ctrl_q = 8'h00; tick(); bus.cfg_wr = 0;
    repeat (3) tick();
    n_cmp++; if (bus.threshold_i !== INIT) begin n_bad++; $display("FAIL hold_thr_i got %h want %h", bus.threshold_i, INIT); end
    n_cmp++; if (bus.threshold_q !== INIT) begin n_bad++; $display("FAIL hold_thr_q got %h want %h", bus.threshold_q, INIT); end
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    n_cmp++; if (bus.thr_update !== 1'b1) begin n_bad++; $display("FAIL cmt_upd got %b want 1", bus.thr_update); end
    n_cmp++; if (bus.threshold_i !== 64'h3000_0000_0000_0000) begin n_bad++; $display("FAIL cmt_thr_i got %h want 3000000000000000", bus.threshold_i); end
    n_cmp++; if (bus.threshold_q !== 64'h0) begin n_bad++; $display("FAIL cmt_thr_q got %h want 0", bus.threshold_q); end
    n_cmp++; if (bus.miss_count !== 32'd1) begin n_bad++; $display("FAIL cmt_miss got %0d want 1", bus.miss_count); end
  endtask

  task automatic test_frame();
    do_reset();
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    bus.pk_done_q = 1; bus.num_peaks_q = 7; tick(); bus.pk_done_q = 0;
    repeat (9) tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL wait_busy got %b want 1", bus.busy); end
    bus.pk_done_i = 1; bus.num_peaks_i = 3; tick(); bus.pk_done_i = 0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL eval_busy got %b want 0", bus.busy); end
    tick();
    n_cmp++; if (bus.frame_count !== 32'd1) begin n_bad++; $display("FAIL frame_cnt got %0d want 1", bus.frame_count); end
    n_cmp++; if (bus.miss_count !== 32'd0) begin n_bad++; $display("FAIL frame_miss got %0d want 0", bus.miss_count); end
    tick();
    n_cmp++; if (bus.frame_count !== 32'd1) begin n_bad++; $display("FAIL single_eval got %0d want 1", bus.frame_count); end
  endtask

  task automatic test_miss();
    do_reset();
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    bus.pk_done_i = 1; tick(); bus.pk_done_i = 0;
    repeat (3) tick();
    bus.iq_first = 1; bus.pk_done_i = 1; bus.pk_done_q = 1; tick();
    drive_idle();
    n_cmp++; if (bus.miss_count !== 32'd1) begin n_bad++; $display("FAIL miss_cnt got %0d want 1", bus.miss_count); end
    n_cmp++; if (bus.frame_count !== 32'd0) begin n_bad++; $display("FAIL miss_frame got %0d want 0", bus.frame_count); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL miss_busy got %b want 1", bus.busy); end
    bus.pk_done_i = 1; tick(); bus.pk_done_i = 0; tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL discard_busy got %b want 1", bus.busy); end
    bus.pk_done_q = 1; tick(); bus.pk_done_q = 0; tick();
    n_cmp++; if (bus.frame_count !== 32'd1) begin n_bad++; $display("FAIL after_miss_frame got %0d want 1", bus.frame_count); end
    bus.pk_done_i = 1; bus.pk_done_q = 1; tick(); drive_idle(); tick();
    n_cmp++; if (bus.frame_count !== 32'd1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_ignore got frame %0d busy %b want 1 0", bus.frame_count, bus.busy); end
  endtask

  task automatic test_cfg_collision_and_reset();
    do_reset();
    bus.cfg_clr = 1; bus.cfg_wr = 1; bus.thr_ctrl_i = 8'hF3; bus.thr_ctrl_q = 8'hF5; tick(); drive_idle();
    tick();
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    n_cmp++; if (bus.threshold_i !== 64'h0) begin n_bad++; $display("FAIL clrwr_thr_i got %h want 0", bus.threshold_i); end
    n_cmp++; if (bus.threshold_q !== 64'h0) begin n_bad++; $display("FAIL clrwr_thr_q got %h want 0", bus.threshold_q); end
    bus.pk_done_i = 1; bus.pk_done_q = 1; tick(); drive_idle(); tick();
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    bus.pk_done_i = 1; tick(); bus.pk_done_i = 0;
    areset = 1; tick(); areset = 0;
    n_cmp++; if (bus.threshold_i !== INIT || bus.threshold_q !== INIT) begin n_bad++; $display("FAIL midrst_thr got %h %h want %h", bus.threshold_i, bus.threshold_q, INIT); end
    n_cmp++; if (bus.frame_count !== 32'd0 || bus.miss_count !== 32'd0) begin n_bad++; $display("FAIL midrst_cnt got %0d %0d want 0 0", bus.frame_count, bus.miss_count); end
    n_cmp++; if (bus.busy !== 1'b0 || bus.thr_update !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b %b want 0 0", bus.busy, bus.thr_update); end
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    n_cmp++; if (bus.threshold_i !== INIT) begin n_bad++; $display("FAIL fresh_thr_i got %h want %h", bus.threshold_i, INIT); end
    bus.pk_done_q = 1; tick(); bus.pk_done_q = 0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL fresh_busy got %b want 1", bus.busy); end
    bus.pk_done_i = 1; tick(); bus.pk_done_i = 0; tick();
    n_cmp++; if (bus.frame_count !== 32'd1) begin n_bad++; $display("FAIL fresh_frame got %0d want 1", bus.frame_count); end
  endtask

`ifdef AUTO_THRESH_EN
  task automatic test_auto();
    logic [63:0] e_i, e_q;
    do_reset();
    bus.auto_en = 1; bus.target_peaks = 16'd4;
    e_i = INIT; e_q = INIT;
    for (int f = 0; f < 60; f++) begin
      bus.iq_first = 1; tick(); bus.iq_first = 0;
      n_cmp++; if (bus.threshold_i !== e_i || bus.threshold_q !== e_q) begin n_bad++; $display("FAIL auto_f%0d got %h %h want %h %h", f, bus.threshold_i, bus.threshold_q, e_i, e_q); end
      if (f == 1) begin
        n_cmp++; if (bus.threshold_i !== 64'h2000_0000_0000_0000) begin n_bad++; $display("FAIL auto_dbl got %h want 2000000000000000", bus.threshold_i); end
        n_cmp++; if (bus.threshold_q !== 64'h0800_0000_0000_0000) begin n_bad++; $display("FAIL auto_half got %h want 0800000000000000", bus.threshold_q); end
      end
      bus.pk_done_i = 1; bus.num_peaks_i = 9; bus.pk_done_q = 1; bus.num_peaks_q = 0; tick(); drive_idle(); tick();
      e_i = model_step(e_i, 9, 4); e_q = model_step(e_q, 0, 4);
    end
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    n_cmp++; if (bus.threshold_i !== 64'h8000_0000_0000_0000) begin n_bad++; $display("FAIL auto_sat got %h want 8000000000000000", bus.threshold_i); end
    n_cmp++; if (bus.threshold_q !== MINT) begin n_bad++; $display("FAIL auto_floor got %h want %h", bus.threshold_q, MINT); end
    // manual config written after EVAL overrides the pending step
    bus.pk_done_i = 1; bus.num_peaks_i = 0; bus.pk_done_q = 1; bus.num_peaks_q = 50; tick(); drive_idle(); tick();
    bus.cfg_wr = 1; bus.thr_ctrl_i = 8'h01; bus.thr_ctrl_q = 8'h00; tick(); drive_idle();
    bus.iq_first = 1; tick(); bus.iq_first = 0;
    n_cmp++; if (bus.threshold_i !== 64'h1000_0000_0000_0001 || bus.threshold_q !== INIT) begin n_bad++; $display("FAIL auto_override got %h %h want 1000000000000001 %h", bus.threshold_i, bus.threshold_q, INIT); end
  endtask
`endif

  task automatic test_random();
    int unsigned tgt;
    logic [31:0] pi, pq;
    logic [7:0]  ci, cq;
    bit          clr, aen;
    int          outcome, order;
    do_reset();
    tgt = $urandom_range(1, 20);
    bus.target_peaks = 16'(tgt);
    m_thr_i = INIT; m_thr_q = INIT; m_sh_i = INIT; m_sh_q = INIT;
    m_st_i = 0; m_st_q = 0; m_dirty = 0; m_pend = 0; m_open = 0; m_frame = 0; m_miss = 0;
    for (int f = 0; f < 40; f++) begin
      if (m_open) m_miss++;
      if (m_dirty) begin m_thr_i = m_sh_i; m_thr_q = m_sh_q; m_dirty = 0; end
      else if (m_pend) begin m_thr_i = m_st_i; m_thr_q = m_st_q; end
      m_pend = 0;
      bus.iq_first = 1; tick(); bus.iq_first = 0;
      m_open = 1;
      aen = 1'($urandom_range(0, 1));
      bus.auto_en = aen;
      n_cmp++; if (bus.threshold_i !== m_thr_i || bus.threshold_q !== m_thr_q) begin n_bad++; $display("FAIL rnd_thr f%0d got %h %h want %h %h", f, bus.threshold_i, bus.threshold_q, m_thr_i, m_thr_q); end
      n_cmp++; if (bus.frame_count !== m_frame || bus.miss_count !== m_miss) begin n_bad++; $display("FAIL rnd_cnt f%0d got %0d %0d want %0d %0d", f, bus.frame_count, bus.miss_count, m_frame, m_miss); end
      n_cmp++; if (bus.thr_update !== 1'b1 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL rnd_upd f%0d got %b %b want 1 1", f, bus.thr_update, bus.busy); end
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        clr = ($urandom_range(0, 3) == 0);
        ci = 8'($urandom); cq = 8'($urandom);
        bus.cfg_clr = clr; bus.cfg_wr = 1; bus.thr_ctrl_i = ci; bus.thr_ctrl_q = cq; tick(); drive_idle();
        if (clr) begin m_sh_i = 0; m_sh_q = 0; end
        else begin m_sh_i = nib_write(m_sh_i, ci); m_sh_q = nib_write(m_sh_q, cq); end
        m_dirty = 1;
      end
      n_cmp++; if (bus.threshold_i !== m_thr_i || bus.threshold_q !== m_thr_q) begin n_bad++; $display("FAIL rnd_nolive f%0d got %h %h want %h %h", f, bus.threshold_i, bus.threshold_q, m_thr_i, m_thr_q); end
      outcome = $urandom_range(0, 3);
      pi = pick_peaks(tgt); pq = pick_peaks(tgt);
      if (outcome <= 1) begin
        order = $urandom_range(0, 2);
        if (order == 0) begin
          bus.pk_done_i = 1; bus.num_peaks_i = pi; bus.pk_done_q = 1; bus.num_peaks_q = pq; tick(); drive_idle();
        end else begin
          if (order == 1) begin bus.pk_done_i = 1; bus.num_peaks_i = pi; end
          else begin bus.pk_done_q = 1; bus.num_peaks_q = pq; end
          tick(); drive_idle();
          repeat ($urandom_range(0, 5)) tick();
          n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rnd_half f%0d got %b want 1", f, bus.busy); end
          if (order == 1) begin bus.pk_done_q = 1; bus.num_peaks_q = pq; end
          else begin bus.pk_done_i = 1; bus.num_peaks_i = pi; end
          tick(); drive_idle();
        end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rnd_eval f%0d got %b want 0", f, bus.busy); end
        m_frame++; m_open = 0;
`ifdef AUTO_THRESH_EN
        if (aen && !m_dirty) begin
          m_st_i = model_step(m_thr_i, pi, tgt); m_st_q = model_step(m_thr_q, pq, tgt); m_pend = 1;
        end
`endif
        if ($urandom_range(0, 1) == 1) begin
          tick();
          bus.pk_done_i = 1; bus.pk_done_q = 1; bus.num_peaks_i = 32'($urandom); bus.num_peaks_q = 32'($urandom);
          tick(); drive_idle();
          n_cmp++; if (bus.frame_count !== m_frame || bus.busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle f%0d got %0d %b want %0d 0", f, bus.frame_count, bus.busy, m_frame); end
        end
      end else begin
        if (outcome == 2) begin
          if ($urandom_range(0, 1) == 1) begin bus.pk_done_i = 1; bus.num_peaks_i = pi; end
          else begin bus.pk_done_q = 1; bus.num_peaks_q = pq; end
        end
        tick(); drive_idle();
        repeat ($urandom_range(0, 3)) tick();
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL rnd_open f%0d got %b want 1", f, bus.busy); end
      end
    end
  endtask

  initial begin
    areset = 1;
    drive_idle();
    bus.auto_en = 0; bus.target_peaks = 0;
    test_reset();
    test_shadow_commit();
    test_frame();
    test_miss();
    test_cfg_collision_and_reset();
`ifdef AUTO_THRESH_EN
    test_auto();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
